// File: rtl/dec_unbinder_pack_35_pkg.sv
// Local types for the pack-35 unbinder: controller states and pipeline flush depth.
package dec_unbinder_pack_35_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_e;

    // Cycles after the last issue until its S3 compare has committed.
    localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing constants, HV types and the global rotate table
// used by every encoder binder pack and its decode-side counterpart.
package hdc_pkg;

    localparam int HV_DIM     = 64;
    localparam int NUM_LEVELS = 4;

    typedef logic [HV_DIM-1:0]             hv_t;
    typedef logic [$clog2(NUM_LEVELS)-1:0] lvl_idx_t;

    // SHIFTS[idx]: the rotate amount the encoder applied to feature idx.
    function automatic int shift_at(input int idx);
        return (idx * 13 + 5) % HV_DIM;
    endfunction

endpackage

// File: rtl/dec_unbinder_pack_35_overlap.sv
// Unbind-and-score pipeline: S1 registers rotr(query, shift[feat]) & level_hv,
// S2 registers the popcount of that mask; feature/level tags travel with the data.
module dec_overlap_stage #(
    parameter int HV_DIM    = 64,
    parameter int NUM_FEATS = 10,
    parameter int BASE_IDX  = 350,
    parameter int FEAT_W    = 4,
    parameter int LVL_W     = 2,
    parameter int SCORE_W   = 7
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_vld,
    input  logic [FEAT_W-1:0]  in_feat,
    input  logic [LVL_W-1:0]   in_lvl,
    input  logic [HV_DIM-1:0]  query,
    input  logic [HV_DIM-1:0]  level_hv,
    output logic               out_vld,
    output logic [FEAT_W-1:0]  out_feat,
    output logic [LVL_W-1:0]   out_lvl,
    output logic [SCORE_W-1:0] out_score
);
    localparam int SH_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

    logic [SH_W-1:0]    shift_tab [NUM_FEATS];
    logic [SH_W-1:0]    shift_sel;

    logic               vld1_q, vld1_d;
    logic [FEAT_W-1:0]  feat1_q, feat1_d;
    logic [LVL_W-1:0]   lvl1_q, lvl1_d;
    logic [HV_DIM-1:0]  masked_q, masked_d;

    logic               vld2_q, vld2_d;
    logic [FEAT_W-1:0]  feat2_q, feat2_d;
    logic [LVL_W-1:0]   lvl2_q, lvl2_d;
    logic [SCORE_W-1:0] score_q, score_d;

    // Per-feature rotate amounts are constants; only the selection is logic.
    for (genvar g = 0; g < NUM_FEATS; g++) begin : g_shift
        assign shift_tab[g] = SH_W'(hdc_pkg::shift_at(BASE_IDX + g) % HV_DIM);
    end

    always_comb begin
        shift_sel = '0;
        for (int i = 0; i < NUM_FEATS; i++) begin
            if (in_feat == FEAT_W'(i)) begin
                shift_sel = shift_tab[i];
            end
        end
    end

    always_comb begin
        vld1_d   = in_vld;
        feat1_d  = in_feat;
        lvl1_d   = in_lvl;
        // Low half of {q,q} >> s is q rotated right by s; s = 0 is identity.
        masked_d = HV_DIM'({query, query} >> shift_sel) & level_hv;

        vld2_d   = vld1_q;
        feat2_d  = feat1_q;
        lvl2_d   = lvl1_q;
        score_d  = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            score_d = score_d + SCORE_W'(masked_q[i]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld1_q   <= 1'b0;
            feat1_q  <= '0;
            lvl1_q   <= '0;
            masked_q <= '0;
            vld2_q   <= 1'b0;
            feat2_q  <= '0;
            lvl2_q   <= '0;
            score_q  <= '0;
        end else begin
            vld1_q   <= vld1_d;
            feat1_q  <= feat1_d;
            lvl1_q   <= lvl1_d;
            masked_q <= masked_d;
            vld2_q   <= vld2_d;
            feat2_q  <= feat2_d;
            lvl2_q   <= lvl2_d;
            score_q  <= score_d;
        end
    end

    assign out_vld   = vld2_q;
    assign out_feat  = feat2_q;
    assign out_lvl   = lvl2_q;
    assign out_score = score_q;

endmodule

// File: rtl/dec_unbinder_pack_35.sv
// Decoder for binder pack 35: scans every (feature, level) pair through the overlap
// pipeline and keeps, per feature, the level with the highest AND-popcount overlap.
module dec_unbinder_pack_35
    import dec_unbinder_pack_35_pkg::*;
#(
    parameter int NUM_FEATS  = 10,
    parameter int BASE_IDX   = 350,
    parameter int NUM_LEVELS = hdc_pkg::NUM_LEVELS,
    parameter int LVL_W      = $clog2(NUM_LEVELS),
    parameter int SCORE_W    = $clog2(hdc_pkg::HV_DIM + 1)
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start_decoding,
    input  hdc_pkg::hv_t                       query_hv,
    input  hdc_pkg::hv_t [NUM_LEVELS-1:0]      level_mem,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_FEATS-1:0][LVL_W-1:0]    decoded_level,
    output logic [NUM_FEATS-1:0][SCORE_W-1:0]  decoded_score,
    output dec_state_e                         dbg_state
);
    localparam int                HV_DIM     = hdc_pkg::HV_DIM;
    localparam int                FEAT_W     = $clog2(NUM_FEATS);
    localparam logic [FEAT_W-1:0] LAST_F     = FEAT_W'(NUM_FEATS - 1);
    localparam logic [LVL_W-1:0]  LAST_L     = LVL_W'(NUM_LEVELS - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    dec_state_e                        state_q, state_d;
    logic [FEAT_W-1:0]                 f_q, f_d;
    logic [LVL_W-1:0]                  l_q, l_d;
    logic [1:0]                        drain_q, drain_d;
    hdc_pkg::hv_t                      query_q, query_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [LVL_W-1:0]                  best_lvl_q, best_lvl_d;
    logic [SCORE_W-1:0]                best_score_q, best_score_d;
    logic [NUM_FEATS-1:0][LVL_W-1:0]   dec_lvl_q, dec_lvl_d;
    logic [NUM_FEATS-1:0][SCORE_W-1:0] dec_score_q, dec_score_d;

    logic                              take_new;
    logic [LVL_W-1:0]                  win_lvl;
    logic [SCORE_W-1:0]                win_score;

    logic                              s2_vld;
    logic [FEAT_W-1:0]                 s2_feat;
    logic [LVL_W-1:0]                  s2_lvl;
    logic [SCORE_W-1:0]                s2_score;

    dec_overlap_stage #(
        .HV_DIM    (HV_DIM),
        .NUM_FEATS (NUM_FEATS),
        .BASE_IDX  (BASE_IDX),
        .FEAT_W    (FEAT_W),
        .LVL_W     (LVL_W),
        .SCORE_W   (SCORE_W)
    ) u_overlap (
        .clk       (clk),
        .nrst      (nrst),
        .in_vld    (state_q == ST_SCAN),
        .in_feat   (f_q),
        .in_lvl    (l_q),
        .query     (query_q),
        .level_hv  (level_mem[l_q]),
        .out_vld   (s2_vld),
        .out_feat  (s2_feat),
        .out_lvl   (s2_lvl),
        .out_score (s2_score)
    );

    always_comb begin
        state_d      = state_q;
        f_d          = f_q;
        l_d          = l_q;
        drain_d      = drain_q;
        query_d      = query_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        best_lvl_d   = best_lvl_q;
        best_score_d = best_score_q;
        dec_lvl_d    = dec_lvl_q;
        dec_score_d  = dec_score_q;
        take_new     = 1'b0;
        win_lvl      = best_lvl_q;
        win_score    = best_score_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_decoding) begin
                    state_d = ST_SCAN;
                    query_d = query_hv;
                    f_d     = '0;
                    l_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (l_q == LAST_L) begin
                    l_d = '0;
                    if (f_q == LAST_F) begin
                        f_d     = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        f_d = f_q + 1'b1;
                    end
                end else begin
                    l_d = l_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Level 0 always seeds the running best; later levels need a strictly
        // larger overlap, so ties stay with the lowest level index.
        if (s2_vld) begin
            take_new = (s2_lvl == '0) || (s2_score > best_score_q);
            if (take_new) begin
                win_lvl   = s2_lvl;
                win_score = s2_score;
            end
            best_lvl_d   = win_lvl;
            best_score_d = win_score;
            if (s2_lvl == LAST_L) begin
                for (int i = 0; i < NUM_FEATS; i++) begin
                    if (s2_feat == FEAT_W'(i)) begin
                        dec_lvl_d[i]   = win_lvl;
                        dec_score_d[i] = win_score;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            f_q          <= '0;
            l_q          <= '0;
            drain_q      <= '0;
            query_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_lvl_q   <= '0;
            best_score_q <= '0;
            dec_lvl_q    <= '0;
            dec_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            f_q          <= f_d;
            l_q          <= l_d;
            drain_q      <= drain_d;
            query_q      <= query_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            best_lvl_q   <= best_lvl_d;
            best_score_q <= best_score_d;
            dec_lvl_q    <= dec_lvl_d;
            dec_score_q  <= dec_score_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign decoded_level = dec_lvl_q;
    assign decoded_score = dec_score_q;
    assign dbg_state     = state_q;

endmodule
